// File: rtl/rover_mission_sequencer.sv
// Mission sequencer for the line-following drive block. Owns the drive block's
// mode input (move_state) and walks a mission through run, obstacle pause,
// overcurrent cooldown/retry and delivery dwell. The mission ends in DONE or FAULT.
// All outputs are registered. move_state is 00 only in RUN, which is the one
// phase where the drive block is allowed to move.

module rover_mission_sequencer #(
   parameter int unsigned DWELL_CYCLES  = 100000000,
   parameter int unsigned CLEAR_CYCLES  = 10000000,
   parameter int unsigned PAUSE_TIMEOUT = 500000000,
   parameter int unsigned OC_FILTER     = 1000,
   parameter int unsigned COOL_CYCLES   = 50000000,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned CNT_W         = 29
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic       ir_obstacle,
   input  logic       limit_a,
   input  logic       limit_b,
   input  logic [1:0] start_stop,
   output logic [1:0] move_state,
   output logic [2:0] phase,
   output logic       delivered,
   output logic       fault,
   output logic [3:0] retry_count
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StRun      = 3'd1,
      StPause    = 3'd2,
      StCooldown = 3'd3,
      StDeliver  = 3'd4,
      StDone     = 3'd5,
      StFault    = 3'd6
   } phase_e;

   // Drive-block mode codes
   localparam logic [1:0] MsRun   = 2'b00;
   localparam logic [1:0] MsIdle  = 2'b01;
   localparam logic [1:0] MsPause = 2'b10;
   localparam logic [1:0] MsHold  = 2'b11;

   localparam logic [1:0] SsEndTape = 2'b10;

   // Filter counters are sized to their own limit, not to the shared timer
   localparam int unsigned OcW  = $clog2(OC_FILTER + 1);
   localparam int unsigned ClrW = $clog2(CLEAR_CYCLES + 1);

   localparam logic [OcW-1:0]   OcMax     = OcW'(OC_FILTER);
   localparam logic [ClrW-1:0]  ClrMax    = ClrW'(CLEAR_CYCLES);
   localparam logic [CNT_W-1:0] DwellLim  = CNT_W'(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] PauseLim  = CNT_W'(PAUSE_TIMEOUT);
   localparam logic [CNT_W-1:0] CoolLim   = CNT_W'(COOL_CYCLES);
   localparam logic [3:0]       RetryLim  = 4'(MAX_RETRIES);

   // ------------------------------------------------------------------------
   // Signal declarations
   // ------------------------------------------------------------------------
   phase_e           phase_q, phase_d;
   logic [3:0]       retry_q, retry_d;
   logic [1:0]       move_state_q, move_state_d;
   logic             fault_q, fault_d;
   logic             delivered_q, delivered_d;

   logic [1:0]       ir_sync_q;
   logic [1:0]       la_sync_q;
   logic [1:0]       lb_sync_q;
   logic             obstacle;
   logic             oc_raw;

   logic [OcW-1:0]   oc_cnt_q, oc_cnt_d;
   logic             oc_trip;

   logic [ClrW-1:0]  clr_cnt_q, clr_cnt_d;
   logic             clear_done;

   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] timer_inc;

   // ------------------------------------------------------------------------
   // Input synchronizers
   // ------------------------------------------------------------------------

   // Two-flop synchronizers for the asynchronous sensor inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_sync_q <= 2'b00;
         la_sync_q <= 2'b00;
         lb_sync_q <= 2'b00;
      end else begin
         ir_sync_q <= {ir_sync_q[0], ir_obstacle};
         la_sync_q <= {la_sync_q[0], limit_a};
         lb_sync_q <= {lb_sync_q[0], limit_b};
      end
   end

   assign obstacle = ir_sync_q[1];
   assign oc_raw   = la_sync_q[1] | lb_sync_q[1];

   // ------------------------------------------------------------------------
   // Overcurrent filter, clear counter and phase timer
   // ------------------------------------------------------------------------

   // Overcurrent counts only while driving; any quiet cycle or other phase clears it
   always_comb begin
      oc_cnt_d = '0;
      if (phase_q == StRun && oc_raw) begin
         oc_cnt_d = (oc_cnt_q == OcMax) ? oc_cnt_q : oc_cnt_q + OcW'(1);
      end
   end

   assign oc_trip = (oc_cnt_q == OcMax);

   // Consecutive obstacle-free cycles while paused
   always_comb begin
      clr_cnt_d = '0;
      if (phase_q == StPause && !obstacle) begin
         clr_cnt_d = (clr_cnt_q == ClrMax) ? clr_cnt_q : clr_cnt_q + ClrW'(1);
      end
   end

   assign clear_done = (clr_cnt_q == ClrMax);

   // timer_inc is the elapsed count including the current cycle, so a limit of N
   // fires on the Nth edge after entering the phase.
   always_comb begin
      timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);
      timer_d   = (phase_d != phase_q) ? '0 : timer_inc;
   end

   // Datapath counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         oc_cnt_q  <= '0;
         clr_cnt_q <= '0;
         timer_q   <= '0;
      end else begin
         oc_cnt_q  <= oc_cnt_d;
         clr_cnt_q <= clr_cnt_d;
         timer_q   <= timer_d;
      end
   end

   // ------------------------------------------------------------------------
   // Mission FSM
   // ------------------------------------------------------------------------

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q      <= StIdle;
         retry_q      <= 4'd0;
         move_state_q <= MsIdle;
         fault_q      <= 1'b0;
         delivered_q  <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         retry_q      <= retry_d;
         move_state_q <= move_state_d;
         fault_q      <= fault_d;
         delivered_q  <= delivered_d;
      end
   end

   // Next phase and retry bookkeeping
   always_comb begin
      phase_d = phase_q;
      retry_d = retry_q;
      unique case (phase_q)
         StIdle: begin
            if (go) begin
               phase_d = StRun;
            end
         end
         StRun: begin
            // Overcurrent beats end tape, which beats obstacle
            if (oc_trip) begin
               retry_d = retry_q + 4'd1;
               phase_d = (retry_d == RetryLim) ? StFault : StCooldown;
            end else if (start_stop == SsEndTape) begin
               phase_d = StDeliver;
            end else if (obstacle) begin
               phase_d = StPause;
            end
         end
         StPause: begin
            // Timeout takes precedence over a simultaneous clear
            if (timer_inc >= PauseLim) begin
               phase_d = StFault;
            end else if (clear_done) begin
               phase_d = StRun;
            end
         end
         StCooldown: begin
            // A motor still over its limit keeps us here indefinitely
            if (timer_inc >= CoolLim && !oc_raw) begin
               phase_d = StRun;
            end
         end
         StDeliver: begin
            if (timer_inc >= DwellLim) begin
               phase_d = StDone;
            end
         end
         StDone: begin
            phase_d = StDone;
         end
         StFault: begin
            phase_d = StFault;
         end
         default: begin
            phase_d = StFault;
         end
      endcase
   end

   // Output values decoded from the upcoming phase so they switch with it
   always_comb begin
      move_state_d = MsIdle;
      fault_d      = 1'b0;
      delivered_d  = 1'b0;
      unique case (phase_d)
         StRun:      move_state_d = MsRun;
         StPause:    move_state_d = MsPause;
         StCooldown: move_state_d = MsHold;
         StFault: begin
            move_state_d = MsHold;
            fault_d      = 1'b1;
         end
         default:    move_state_d = MsIdle;
      endcase
      if (phase_q == StDeliver && phase_d == StDone) begin
         delivered_d = 1'b1;
      end
   end

   assign phase       = phase_q;
   assign retry_count = retry_q;
   assign move_state  = move_state_q;
   assign fault       = fault_q;
   assign delivered   = delivered_q;

endmodule
